cordic_share_ctrl: RTL and testbench
====================================

Name: cordic_share_ctrl

Overview:
- Round-robin scheduler that shares one iterative CORDIC cosine core between two custom-instruction requesters (A, B).
- Accepts a float operand from the granted requester and issues the core's start/clk_en sequence.
- Captures the core's float result on its done flag, returns it to the owner with a one-cycle done pulse, and recovers from a hung core by timeout.
- Sits between the processor-side instruction ports and a single cosine core instance.

Parameters:
- DATA_W, 32, float operand/result width.
- TIMEOUT, 24, max RUN cycles waiting for core_done before abort (must be ≥ 17).
- TO_RESULT, 32'h7FC00000, result returned on timeout (quiet NaN).

Ports:
- clock  in  1  system clock
- aclr  in  1  asynchronous active-high reset
- req_a  in  1  requester A request, level, held until done_a
- dataa_a  in  DATA_W  A operand, stable while req_a high
- done_a  out  1  one-cycle pulse, result_a valid
- result_a  out  DATA_W  A result, holds until next done_a
- req_b  in  1  requester B request
- dataa_b  in  DATA_W  B operand
- done_b  out  1  B done pulse
- result_b  out  DATA_W  B result
- core_clk_en  out  1  core clock enable
- core_start  out  1  core load strobe
- core_dataa  out  DATA_W  operand to core
- core_done  in  1  core iteration-complete flag
- core_result  in  DATA_W  core float result
- busy  out  1  state != IDLE
- owner  out  1  current/last grant (0=A, 1=B)
- err  out  1  sticky timeout flag, cleared only by aclr

Behaviour:
- Reset (async, aclr=1): state=IDLE; rr_ptr=0 (A preferred); owner=0; err=0; done_*=0; result_*=0; core_* outputs=0; op_reg=0; cnt=0.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester selected by rr_ptr.
  - On grant: latch its operand into op_reg, set owner, go to LOAD.
  - No req: stay in IDLE.
- LOAD (1 cycle): core_start=1, core_clk_en=1, core_dataa=op_reg; cnt cleared; go to RUN.
- RUN:
  - core_start=0; core_clk_en = !core_done; cnt increments each cycle.
  - core_done=1: capture core_result into result_<owner>, go to RESP.
  - Else if cnt reaches TIMEOUT-1: load TO_RESULT into result_<owner>, set err=1, go to RESP.
- RESP (1 cycle): done_<owner>=1; rr_ptr = ~owner; go to IDLE.
- core_dataa is driven from op_reg in every state.
- Latency with a standard 16-iteration core: req sampled in IDLE at cycle 0, LOAD at 1, RUN at 2..18 (core_done seen at 18), done pulse at cycle 19. Gap between back-to-back grants is 1 IDLE cycle.
- Requesters must drop req the cycle after their done. The IDLE cycle following RESP re-arbitrates, and rr_ptr already favours the other requester.
- Request changes mid-operation: a req that drops while it is being served is ignored; the operation completes and done still pulses. A req asserted during busy waits; it is not lost and is served next.
- Only one done_* is ever high at a time.
- Reset mid-operation aborts immediately: no done pulse, and the core is left un-enabled.
- core_done high in IDLE or LOAD is ignored.
- cnt width: ceil(log2(TIMEOUT))+1 bits, saturates.

Test Plan:
- Reset, then req_a=1 with dataa_a=32'h3F800000; stub core raises core_done 17 cycles after start with core_result=32'h3F0A5140 → core_start high exactly cycle 1, core_dataa=32'h3F800000, done_a at cycle 19, result_a=32'h3F0A5140, done_b never high.
- req_a and req_b rise together (A=32'h3F800000, B=32'h40000000) → A served first (done_a cycle 19); B granted in the following IDLE, done_b 20 cycles later with result_b = stub value; owner 0 then 1.
- Both requesters continuously re-request for 4 operations → grant order A,B,A,B; no requester is served twice in a row while the other waits.
- Stub core never asserts core_done → done_a pulses after LOAD + TIMEOUT RUN cycles with result_a=32'h7FC00000 and err=1 (sticky); the next normal request completes and err stays 1.
- aclr pulsed at RUN cycle 5 → busy=0, done_*=0, core_clk_en=0 within the same cycle; a fresh req_b afterwards completes normally with owner=1.
- core_done held high while IDLE, and req_b dropped mid-RUN → no spurious done; the in-flight B operation still returns done_b once.

Source files
------------

// File: rtl/cordic_share_ctrl.sv
// cordic_share_ctrl: round-robin sharing of one iterative CORDIC cosine core between two requesters,
// with a timeout that returns a quiet NaN and raises a sticky error when the core never finishes.
module cordic_share_ctrl #(
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT   = 24,
    parameter logic [DATA_W-1:0] TO_RESULT = 32'h7FC00000
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              req_a,
    input  logic [DATA_W-1:0] dataa_a,
    output logic              done_a,
    output logic [DATA_W-1:0] result_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] dataa_b,
    output logic              done_b,
    output logic [DATA_W-1:0] result_b,
    output logic              core_clk_en,
    output logic              core_start,
    output logic [DATA_W-1:0] core_dataa,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              busy,
    output logic              owner,
    output logic              err
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] res_a_q, res_a_d;
    logic [DATA_W-1:0] res_b_q, res_b_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              gnt;
    logic [DATA_W-1:0] res;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        err_d   = err_q;
        res_a_d = res_a_q;
        res_b_d = res_b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        gnt     = (req_a && req_b) ? rr_q : req_b;
        res     = core_done ? core_result : TO_RESULT;
        case (state_q)
            IDLE: if (req_a || req_b) begin
                owner_d = gnt;
                op_d    = gnt ? dataa_b : dataa_a;
                state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                // core_done wins over a timeout landing on the same cycle
                if (core_done || cnt_q == CMAX) begin
                    res_a_d = owner_q ? res_a_q : res;
                    res_b_d = owner_q ? res : res_b_q;
                    err_d   = err_q | ~core_done;
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_d    = ~owner_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            res_a_q <= '0;
            res_b_q <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            res_a_q <= res_a_d;
            res_b_q <= res_b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign core_start  = state_q == LOAD;
    assign core_clk_en = state_q == LOAD || (state_q == RUN && !core_done);
    assign core_dataa  = op_q;
    assign done_a      = state_q == RESP && !owner_q;
    assign done_b      = state_q == RESP && owner_q;
    assign result_a    = res_a_q;
    assign result_b    = res_b_q;
    assign busy        = state_q != IDLE;
    assign owner       = owner_q;
    assign err         = err_q;
endmodule

// File: tb/tb_cordic_share_ctrl.sv
// tb_cordic_share_ctrl: directed bench with a stub core that finishes 17 cycles after start.
module tb_cordic_share_ctrl;
    logic        clock = 1'b0;
    logic        aclr  = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [31:0] dataa_a = '0, dataa_b = '0;
    logic        done_a, done_b, core_clk_en, core_start, core_done, busy, owner, err;
    logic [31:0] result_a, result_b, core_dataa;
    logic [31:0] stub_res = '0;
    logic        hang = 1'b0, force_done = 1'b0;
    int          sc = 0;

    int checks = 0, errors = 0;
    int t, n_start, t_start, n_done_a, n_done_b, t_done_a, t_done_b, both = 0;
    int reps_a, reps_b, nseq;
    int seq[8];
    logic        pend_a, pend_b, o_done;
    logic [31:0] start_data;

    cordic_share_ctrl dut (
        .clock(clock), .aclr(aclr),
        .req_a(req_a), .dataa_a(dataa_a), .done_a(done_a), .result_a(result_a),
        .req_b(req_b), .dataa_b(dataa_b), .done_b(done_b), .result_b(result_b),
        .core_clk_en(core_clk_en), .core_start(core_start), .core_dataa(core_dataa),
        .core_done(core_done), .core_result(stub_res),
        .busy(busy), .owner(owner), .err(err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (core_start) begin
            sc <= 1;
            stub_res <= (core_dataa == 32'h3F800000) ? 32'h3F0A5140 : 32'hBED51C8A;
        end else if (sc != 0 && sc < 17) sc <= sc + 1;
    end
    assign core_done = force_done || (!hang && sc == 17);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear();
        t = 0; n_start = 0; t_start = -1; n_done_a = 0; n_done_b = 0;
        t_done_a = -1; t_done_b = -1; nseq = 0; reps_a = 0; reps_b = 0;
        pend_a = 1'b0; pend_b = 1'b0; o_done = 1'bx; start_data = 'x;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        t++;
        if (pend_a) begin req_a = 1'b1; pend_a = 1'b0; end
        if (pend_b) begin req_b = 1'b1; pend_b = 1'b0; end
        if (core_start) begin n_start++; t_start = t; start_data = core_dataa; end
        if (done_a && done_b) both++;
        if (done_a) begin
            n_done_a++; t_done_a = t; req_a = 1'b0; o_done = owner;
            if (nseq < 8) begin seq[nseq] = 0; nseq++; end
            if (reps_a > 0) begin pend_a = 1'b1; reps_a--; end
        end
        if (done_b) begin
            n_done_b++; t_done_b = t; req_b = 1'b0; o_done = owner;
            if (nseq < 8) begin seq[nseq] = 1; nseq++; end
            if (reps_b > 0) begin pend_b = 1'b1; reps_b--; end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        ticks(2);
        aclr = 1'b0;
        ticks(1);
    endtask

    initial begin
        clear();
        #1;
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_err", err, 0);
        check("rst_done", {done_a, done_b}, 0);
        check("rst_res", result_a | result_b, 0);
        check("rst_core", {core_start, core_clk_en}, 0);
        check("rst_dataa", core_dataa, 0);
        do_reset();

        clear();
        dataa_a = 32'h3F800000; dataa_b = 32'h40000000;
        req_a = 1'b1;
        ticks(25);
        check("t1_start_cyc", t_start, 1);
        check("t1_start_cnt", n_start, 1);
        check("t1_dataa", start_data, 32'h3F800000);
        check("t1_done_cyc", t_done_a, 19);
        check("t1_result", result_a, 32'h3F0A5140);
        check("t1_no_done_b", n_done_b, 0);
        check("t1_err", err, 0);

        do_reset();
        clear();
        req_a = 1'b1; req_b = 1'b1;
        ticks(45);
        check("t2_done_a_cyc", t_done_a, 19);
        check("t2_done_b_cyc", t_done_b, 39);
        check("t2_result_a", result_a, 32'h3F0A5140);
        check("t2_result_b", result_b, 32'hBED51C8A);
        check("t2_order", {seq[0][0], seq[1][0]}, 2'b01);
        check("t2_owner", o_done, 1);

        clear();
        reps_a = 1; reps_b = 1;
        req_a = 1'b1; req_b = 1'b1;
        ticks(90);
        check("t3_ops", nseq, 4);
        check("t3_order", {seq[0][0], seq[1][0], seq[2][0], seq[3][0]}, 4'b0101);

        clear();
        hang = 1'b1;
        req_a = 1'b1;
        ticks(30);
        check("t4_to_cyc", t_done_a, 26);
        check("t4_to_result", result_a, 32'h7FC00000);
        check("t4_err", err, 1);
        hang = 1'b0;
        clear();
        req_a = 1'b1;
        ticks(25);
        check("t4_next_cyc", t_done_a, 19);
        check("t4_next_result", result_a, 32'h3F0A5140);
        check("t4_err_sticky", err, 1);

        clear();
        req_b = 1'b1;
        ticks(6);
        check("t5_busy_pre", busy, 1);
        req_b = 1'b0;
        aclr = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_done", {done_a, done_b}, 0);
        check("t5_clk_en", core_clk_en, 0);
        check("t5_err_clr", err, 0);
        ticks(2);
        aclr = 1'b0;
        ticks(3);
        check("t5_no_done", n_done_a + n_done_b, 0);
        clear();
        req_b = 1'b1;
        ticks(25);
        check("t5_b_cyc", t_done_b, 19);
        check("t5_b_owner", o_done, 1);
        check("t5_b_result", result_b, 32'hBED51C8A);

        clear();
        force_done = 1'b1;
        ticks(5);
        check("t6_idle_done", n_done_a + n_done_b, 0);
        check("t6_idle_busy", busy, 0);
        force_done = 1'b0;
        clear();
        req_b = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (t == 8) req_b = 1'b0;
        end
        check("t6_done_b_once", n_done_b, 1);
        check("t6_done_b_cyc", t_done_b, 19);
        check("t6_no_done_a", n_done_a, 0);
        check("one_done", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
